spi_frame_slave: RTL
====================

// Module: spi_frame_slave
// PURPOSE
//  Parametrised SPI slave (mode 0) fully in the clk domain; generalises the 32-bit sck-clocked slave.
//  Oversamples sck/cs_n/sdo through synchronisers and frames transfers with cs_n.
//  Double-buffers received words so q changes only on a commit edge (vsync).
//  Flags short frames and overruns. Sits between the PIC SPI links and the data decoder.
// PARAMETERS
//  WIDTH        32     bits per frame (8..64)
//  SYNC_STAGES  2      synchroniser flops on sck, cs_n, sdo (>=2)
//  RESET_Q      '0     reset value of q and pending buffer
// PORTS
//  clk        in   1      system clock; must be >= 8x sck frequency
//  reset      in   1      synchronous, active-high
//  sck        in   1      SPI clock from PIC, async
//  cs_n       in   1      SPI frame select from PIC, active low, async
//  sdo        in   1      serial data from PIC, async
//  sdi        out  1      serial data to PIC
//  d          in   WIDTH  word to transmit; sampled at frame start
//  commit     in   1      level input (vsync); rising edge publishes pending word
//  q          out  WIDTH  committed received word
//  rx_valid   out  1      1-cycle pulse: full frame received into pending buffer
//  frame_err  out  1      1-cycle pulse: cs_n rose before WIDTH bits
//  overrun    out  1      sticky: pending word overwritten before commit
// BEHAVIOUR
//  Reset: q=RESET_Q, pending=RESET_Q, sdi=0, rx_valid=0, frame_err=0, overrun=0, FSM=RESYNC.
//  Edges from synchronised signals: sck_rise, sck_fall, cs_fall, cs_rise, commit_rise (1 clk each).
//  FSM: RESYNC -> IDLE when sync cs_n=1 (never starts mid-frame after reset).
//   IDLE  : on cs_fall -> SHIFT; txsr<=d (or echo); bitcnt<=0; sdi<=MSB of loaded word.
//   SHIFT : sck_rise: rxsr<={rxsr[WIDTH-2:0],sdo_sync}, bitcnt++ ;
//           sck_fall: txsr<<=1, sdi<=next bit; bitcnt==WIDTH after sample -> DONE.
//           cs_rise with 0<bitcnt<WIDTH -> frame_err pulse, data discarded, -> IDLE.
//           cs_rise with bitcnt==0 -> IDLE silently.
//   DONE  : 1 cycle: pending<=rxsr, rx_valid=1, ->HOLD.
//   HOLD  : extra sck edges ignored, sdi=0; cs_rise -> IDLE.
//  Commit: on commit_rise, q<=pending, next cycle. Latency sdo bit -> q: sync + 1 + commit.
//  Simultaneous DONE write and commit_rise: q takes the NEW word (bypass); no overrun.
//  Overrun: DONE while a previous pending word is uncommitted -> overrun<=1 (sticky until reset);
//   pending overwritten by newer word.
//  cs_fall while in SHIFT impossible; cs_fall in HOLD/RESYNC ignored.
//  sck_rise and cs_rise same cycle: cs_rise wins, sample dropped.
//  reset mid-frame: all state cleared, RESYNC waits for cs_n high.
// CONFIGURATION
//  SPI_ECHO_EN defined: frame-start load takes pending (last received word) instead of d;
//   d is ignored. Undefined: txsr loads d. Receive path identical in both builds.
// TESTING
//  WIDTH=32, send 0xDEADBEEF, commit pulse -> rx_valid once, q=0xDEADBEEF after commit, not before.
//  cs_n high after 12 bits -> frame_err pulse, pending/q unchanged, next full frame accepted.
//  Two frames 0x11111111, 0x22222222, no commit between -> overrun=1, commit gives q=0x22222222.
//  d=0xA5A5A5A5, 32 sck cycles -> sdi bits read by bench on sck rise = 0xA5A5A5A5 MSB first;
//   with SPI_ECHO_EN after prior frame 0x12345678 -> sdi returns 0x12345678.
//  Assert reset with cs_n low at bit 10, release, finish frame -> no rx_valid; next frame OK.
//  WIDTH=8, commit_rise same cycle as DONE of 0x3C -> q=0x3C, overrun=0.

Source files
------------

// File: rtl/spi_frame_slave.sv
// Mode-0 SPI slave oversampled in the clk domain, with a double-buffered receive word published on commit.
// Optional build macro SPI_ECHO_EN: each frame transmits the last received word instead of d.
module spi_frame_slave #(
  parameter int                WIDTH       = 32,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]  RESET_Q     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             sdo,
  output logic             sdi,
  input  logic [WIDTH-1:0] d,
  input  logic             commit,
  output logic [WIDTH-1:0] q,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    RESYNC = 3'd0,
    IDLE   = 3'd1,
    SHIFT  = 3'd2,
    DONE   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_r, cs_sync_r, sdo_sync_r;
  logic                   sck_d_r, cs_d_r, commit_d_r;
  logic                   sck_s, cs_s, sdo_s;
  logic                   sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s, commit_rise_s;
  logic [WIDTH-1:0]       load_s;

  state_t                 state_r;
  logic [WIDTH-1:0]       txsr_r, rxsr_r, pending_r, q_r;
  logic [CW-1:0]          bitcnt_r;
  logic                   pend_valid_r, sdi_r, rx_valid_r, frame_err_r, overrun_r;

  // Synchroniser chains; cs_n resets to "selected" so RESYNC only leaves on a genuinely high cs_n
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_r <= '0;
      cs_sync_r  <= '0;
      sdo_sync_r <= '0;
      sck_d_r    <= 1'b0;
      cs_d_r     <= 1'b0;
      commit_d_r <= 1'b1;
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], sck};
      cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      sdo_sync_r <= {sdo_sync_r[SYNC_STAGES-2:0], sdo};
      sck_d_r    <= sck_s;
      cs_d_r     <= cs_s;
      commit_d_r <= commit;
    end
  end

  assign sck_s         = sck_sync_r[SYNC_STAGES-1];
  assign cs_s          = cs_sync_r[SYNC_STAGES-1];
  assign sdo_s         = sdo_sync_r[SYNC_STAGES-1];
  assign sck_rise_s    = sck_s & ~sck_d_r;
  assign sck_fall_s    = ~sck_s & sck_d_r;
  assign cs_rise_s     = cs_s & ~cs_d_r;
  assign cs_fall_s     = ~cs_s & cs_d_r;
  assign commit_rise_s = commit & ~commit_d_r;

`ifdef SPI_ECHO_EN
  assign load_s = pending_r;
`else
  assign load_s = d;
`endif

  // Frame FSM, receive/transmit shifters, pending buffer and commit path
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= RESYNC;
      txsr_r       <= '0;
      rxsr_r       <= '0;
      bitcnt_r     <= '0;
      pending_r    <= RESET_Q;
      pend_valid_r <= 1'b0;
      q_r          <= RESET_Q;
      sdi_r        <= 1'b0;
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (commit_rise_s) begin
        q_r          <= pending_r;
        pend_valid_r <= 1'b0;
      end
      case (state_r)
        RESYNC: begin
          sdi_r <= 1'b0;
          if (cs_s) state_r <= IDLE;
        end
        IDLE: begin
          sdi_r <= 1'b0;
          if (cs_fall_s) begin
            txsr_r   <= load_s;
            bitcnt_r <= '0;
            sdi_r    <= load_s[WIDTH-1];
            state_r  <= SHIFT;
          end
        end
        SHIFT: begin
          // cs_rise beats a coincident sck_rise: the sample is dropped
          if (cs_rise_s) begin
            sdi_r   <= 1'b0;
            if (bitcnt_r != CW'(0)) frame_err_r <= 1'b1;
            state_r <= IDLE;
          end else if (sck_rise_s) begin
            rxsr_r   <= {rxsr_r[WIDTH-2:0], sdo_s};
            bitcnt_r <= bitcnt_r + CW'(1);
            if (bitcnt_r == CW'(WIDTH - 1)) state_r <= DONE;
          end else if (sck_fall_s) begin
            txsr_r <= {txsr_r[WIDTH-2:0], 1'b0};
            sdi_r  <= txsr_r[WIDTH-2];
          end
        end
        DONE: begin
          pending_r  <= rxsr_r;
          rx_valid_r <= 1'b1;
          sdi_r      <= 1'b0;
          // A commit landing on this cycle bypasses straight to q and consumes the new word
          if (commit_rise_s) begin
            q_r          <= rxsr_r;
            pend_valid_r <= 1'b0;
          end else begin
            pend_valid_r <= 1'b1;
            if (pend_valid_r) overrun_r <= 1'b1;
          end
          state_r <= cs_rise_s ? IDLE : HOLD;
        end
        HOLD: begin
          sdi_r <= 1'b0;
          if (cs_rise_s) state_r <= IDLE;
        end
        default: begin
          sdi_r   <= 1'b0;
          state_r <= RESYNC;
        end
      endcase
    end
  end

  assign sdi       = sdi_r;
  assign q         = q_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule
